// File: rtl/adc_frame_packer.sv
// Decimates the 12-bit AD9226 stream and packs samples into byte frames for the ADC FIFO.
// Define ADC_FRAME_CSUM_EN to append an XOR checksum byte after the last sample.
module adc_frame_packer #(
  parameter int         DECIM             = 4,
  parameter int         SAMPLES_PER_FRAME = 8,
  parameter logic [7:0] SYNC_BYTE         = 8'hA5
) (
  input  logic        ad_clk,
  input  logic        RST_n,
  input  logic [11:0] ad,
  input  logic        enable,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt,
  output logic        busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SYNC   = 3'd1;
  localparam logic [2:0] HI     = 3'd2;
  localparam logic [2:0] LO     = 3'd3;
  localparam logic [2:0] WAIT_S = 3'd4;
`ifdef ADC_FRAME_CSUM_EN
  localparam logic [2:0] CSUM   = 3'd5;
`endif

  localparam logic [7:0] D_LAST = 8'(DECIM - 1);
  localparam logic [7:0] S_LAST = 8'(SAMPLES_PER_FRAME - 1);

  logic [2:0]  state_r, state_s;
  logic [11:0] ad_q_r;
  logic [11:0] sample_r, sample_s;
  logic [7:0]  dcnt_r;
  logic [7:0]  scnt_r, scnt_s;
  logic        strobe_s;
  logic        wr_en_s;
  logic [7:0]  wr_data_s;
  logic        frame_inc_s;
  logic        drop_inc_s;
`ifdef ADC_FRAME_CSUM_EN
  logic [7:0]  csum_r, csum_s;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign strobe_s = enable && (dcnt_r == D_LAST);

  // Next-state, write request and counter-event decode
  always_comb begin
    state_s     = state_r;
    sample_s    = sample_r;
    scnt_s      = scnt_r;
    wr_en_s     = 1'b0;
    wr_data_s   = 8'h00;
    frame_inc_s = 1'b0;
    drop_inc_s  = 1'b0;
`ifdef ADC_FRAME_CSUM_EN
    csum_s      = csum_r;
`endif
    case (state_r)
      IDLE: begin
        if (strobe_s && fifo_full) begin
          drop_inc_s = 1'b1;
        end else if (strobe_s) begin
          state_s  = SYNC;
          sample_s = ad_q_r;
          scnt_s   = 8'd0;
`ifdef ADC_FRAME_CSUM_EN
          csum_s   = 8'h00;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SYNC: begin
        if (fifo_full) begin
          drop_inc_s = 1'b1;
          state_s    = IDLE;
        end else begin
          wr_en_s   = 1'b1;
          wr_data_s = SYNC_BYTE;
          state_s   = HI;
        end
      end
      HI: begin
        if (fifo_full) begin
          drop_inc_s = 1'b1;
          state_s    = IDLE;
        end else begin
          wr_en_s   = 1'b1;
          wr_data_s = {4'h0, sample_r[11:8]};
`ifdef ADC_FRAME_CSUM_EN
          csum_s    = csum_add(csum_r, wr_data_s);
`endif
          state_s   = LO;
        end
      end
      LO: begin
        if (fifo_full) begin
          drop_inc_s = 1'b1;
          state_s    = IDLE;
        end else begin
          wr_en_s   = 1'b1;
          wr_data_s = sample_r[7:0];
          scnt_s    = scnt_r + 8'd1;
`ifdef ADC_FRAME_CSUM_EN
          csum_s    = csum_add(csum_r, wr_data_s);
`endif
          if (scnt_r == S_LAST) begin
`ifdef ADC_FRAME_CSUM_EN
            state_s = CSUM;
`else
            state_s     = IDLE;
            frame_inc_s = 1'b1;
`endif
          end else begin
            state_s = WAIT_S;
          end
        end
      end
      WAIT_S: begin
        // An enable drop between samples abandons the frame without a drop count
        if (strobe_s) begin
          state_s  = HI;
          sample_s = ad_q_r;
        end else if (!enable) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_S;
        end
      end
`ifdef ADC_FRAME_CSUM_EN
      CSUM: begin
        if (fifo_full) begin
          drop_inc_s = 1'b1;
          state_s    = IDLE;
        end else begin
          wr_en_s     = 1'b1;
          wr_data_s   = csum_r;
          frame_inc_s = 1'b1;
          state_s     = IDLE;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath, counters and registered FIFO write port
  always_ff @(posedge ad_clk) begin
    if (!RST_n) begin
      state_r      <= IDLE;
      ad_q_r       <= 12'h000;
      sample_r     <= 12'h000;
      dcnt_r       <= 8'd0;
      scnt_r       <= 8'd0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= 8'h00;
      frame_cnt    <= 16'h0000;
      drop_cnt     <= 8'h00;
      busy         <= 1'b0;
`ifdef ADC_FRAME_CSUM_EN
      csum_r       <= 8'h00;
`endif
    end else begin
      ad_q_r       <= ad;
      state_r      <= state_s;
      sample_r     <= sample_s;
      scnt_r       <= scnt_s;
      fifo_wr_en   <= wr_en_s;
      fifo_wr_data <= wr_data_s;
      busy         <= (state_s != IDLE);
`ifdef ADC_FRAME_CSUM_EN
      csum_r       <= csum_s;
`endif
      if (!enable || (dcnt_r == D_LAST)) begin
        dcnt_r <= 8'd0;
      end else begin
        dcnt_r <= dcnt_r + 8'd1;
      end
      if (frame_inc_s) begin
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        frame_cnt <= frame_cnt;
      end
      if (drop_inc_s && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end else begin
        drop_cnt <= drop_cnt;
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Self-checking bench for adc_frame_packer: random samples per decimation window,
// expected byte stream built frame by frame from the window values.
module tb_adc_frame_packer;
  localparam int D   = 4;
  localparam int SPF = 2;

  logic        ad_clk = 1'b0;
  logic        RST_n = 1'b0;
  logic [11:0] ad = 12'h000;
  logic        enable = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;
  logic        busy;

  adc_frame_packer #(.DECIM(D), .SAMPLES_PER_FRAME(SPF), .SYNC_BYTE(8'hA5)) dut (
    .ad_clk(ad_clk), .RST_n(RST_n), .ad(ad), .enable(enable), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 ad_clk = ~ad_clk;

  int checks = 0;
  int errors = 0;
  logic [8:0]  expq[$];
  logic [11:0] dirq[$];
  int phase = 0, pos = 0, fidx = 0;
  int exp_frames = 0, exp_drops = 0;
  int inject_idx = -1, endrop_idx = -1, rst_idx = -1;
  bit model_on = 1'b0, stop_req = 1'b0, full_pulse = 1'b0, rst_pulse = 1'b0;
  logic [7:0] csum_m = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bytes of one sample; frame opens with the sync byte, optionally closes with XOR of sample bytes
  task automatic push_window(input logic [11:0] v);
    logic [7:0] hi, lo;
    bit last;
    hi = {4'h0, v[11:8]};
    lo = v[7:0];
    if (pos == 0) begin
      expq.push_back({1'b0, 8'hA5});
      csum_m = 8'h00;
    end
    csum_m = csum_m ^ hi ^ lo;
    last = (pos == SPF - 1);
    expq.push_back({1'b0, hi});
`ifdef ADC_FRAME_CSUM_EN
    expq.push_back({1'b0, lo});
    if (last) expq.push_back({1'b1, csum_m});
`else
    expq.push_back({last, lo});
`endif
    pos = (pos + 1) % SPF;
  endtask

  task automatic abort_frame();
    logic [8:0] e;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      if (e[8]) break;
    end
    fidx = 0;
  endtask

  task automatic drive();
    logic [11:0] v;
    if (enable && model_on) begin
      if (phase == 0 && stop_req && pos == 0) begin
        enable = 1'b0;
        stop_req = 1'b0;
      end else begin
        if (phase == 0) begin
          v = (dirq.size() > 0) ? dirq.pop_front() : 12'($urandom);
          ad = v;
          push_window(v);
        end
        phase = (phase + 1) % D;
      end
    end
  endtask

  task automatic tick();
    logic [8:0] e;
    @(negedge ad_clk);
    if (full_pulse) begin fifo_full = 1'b0; full_pulse = 1'b0; end
    if (rst_pulse) begin RST_n = 1'b1; rst_pulse = 1'b0; end
    if (fifo_wr_en) begin
      if (expq.size() == 0) begin
        chk("stray_write", 32'(fifo_wr_en), 32'd0);
      end else begin
        e = expq.pop_front();
        chk("byte", 32'(fifo_wr_data), 32'(e[7:0]));
        if (e[8]) begin exp_frames++; fidx = 0; end
        else fidx++;
        if (fidx == inject_idx) begin
          fifo_full = 1'b1; full_pulse = 1'b1; inject_idx = -1;
          abort_frame(); exp_drops++;
        end
        if (fidx == endrop_idx) begin
          enable = 1'b0; endrop_idx = -1;
          abort_frame();
        end
        if (fidx == rst_idx) begin
          RST_n = 1'b0; rst_pulse = 1'b1; rst_idx = -1; enable = 1'b0;
          expq.delete(); pos = 0; fidx = 0; exp_frames = 0; exp_drops = 0;
        end
      end
    end
    drive();
  endtask

  task automatic start_capture();
    model_on = 1'b1;
    phase = 0;
    enable = 1'b1;
    drive();
  endtask

  task automatic drain(input string tag);
    stop_req = 1'b1;
    for (int i = 0; i < 200 && (enable || expq.size() > 0); i++) tick();
    repeat (4) tick();
    chk({tag, "_missing_bytes"}, 32'(expq.size()), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames[15:0]));
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drops));
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    RST_n = 1'b1;
    tick();
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Directed frame 123 / 456
    dirq.push_back(12'h123);
    dirq.push_back(12'h456);
    start_capture();
    drain("directed");
    chk("directed_one_frame", 32'(frame_cnt), 32'd1);

    // Random samples over many consecutive frames
    start_capture();
    repeat (20 * D) tick();
    drain("random");

    // fifo_full on the LO byte of sample 1
    inject_idx = 4;
    start_capture();
    repeat (12 * D) tick();
    drain("full_at_lo");
    chk("full_at_lo_drop", 32'(drop_cnt), 32'd1);

    // enable dropped in WAIT
    endrop_idx = 3;
    start_capture();
    for (int i = 0; i < 100 && enable; i++) tick();
    chk("endrop_reached", 32'(enable), 32'd0);
    tick();
    chk("endrop_busy", 32'(busy), 32'd0);
    chk("endrop_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    repeat (10) tick();
    start_capture();
    repeat (6 * D) tick();
    drain("after_endrop");

    // Reset in state HI
    rst_idx = 1;
    start_capture();
    for (int i = 0; i < 100 && !rst_pulse; i++) tick();
    chk("midrst_reached", 32'(rst_pulse), 32'd1);
    tick();
    chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("midrst_wr_data", 32'(fifo_wr_data), 32'd0);
    repeat (10) tick();

    // fifo_full held for 300 strobes: saturating drops, never a write
    model_on = 1'b0;
    fifo_full = 1'b1;
    enable = 1'b1;
    repeat (300 * D + 2) tick();
    enable = 1'b0;
    tick();
    chk("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
    chk("sat_frame_cnt", 32'(frame_cnt), 32'd0);
    fifo_full = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
